// File: rtl/counter_btn_ctrl_pkg.sv
// Shared definitions for the push-button control stage of universal_bin_counter.
//
// Contents:
//   - Debounce FSM state encodings (ZERO, WAIT1, ONE, WAIT0).
//   - Command indices (CMD_UP, CMD_DN, CMD_LOAD, CMD_CLR). They index the
//     per-button vectors in the top level and the db_level output bits.
package counter_btn_ctrl_pkg;

  // Debounce FSM states
  localparam logic [1:0] ZERO  = 2'b00;  // settled low
  localparam logic [1:0] WAIT1 = 2'b01;  // low, input high, timing the rise
  localparam logic [1:0] ONE   = 2'b10;  // settled high
  localparam logic [1:0] WAIT0 = 2'b11;  // high, input low, timing the fall

  // Command indices. Arbitration priority runs from CMD_CLR down to CMD_DN.
  localparam int CMD_UP   = 0;
  localparam int CMD_DN   = 1;
  localparam int CMD_LOAD = 2;
  localparam int CMD_CLR  = 3;

  localparam int NUM_BTN = 4;

endpackage

// File: rtl/counter_btn_ctrl_debounce_fsm.sv
// debounce_fsm: synchroniser plus debouncer for one raw push-button.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   synchronous, active-low reset
//   din_raw  in   raw asynchronous button, active-high
//   level    out  debounced level (high in ONE and WAIT0)
//   tick     out  one-cycle pulse on the WAIT1 -> ONE transition
//   state    out  current FSM state, for observation
//
// The input must stay stable for 2^DB_W cycles before the debounced level
// changes. The tick is combinational from registered state, so it lines up
// with the edge on which the FSM enters ONE.
module debounce_fsm
  import counter_btn_ctrl_pkg::*;
#(
  parameter int DB_W = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       din_raw,
  output logic       level,
  output logic       tick,
  output logic [1:0] state
);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic [1:0]      state_q, state_d;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic            din;

  // Two-flop synchroniser
  assign sync1_d = din_raw;
  assign sync2_d = sync1_q;
  assign din     = sync2_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tick    = 1'b0;
    case (state_q)
      ZERO: begin
        if (din) begin
          state_d = WAIT1;
          cnt_d   = '0;
        end
      end
      WAIT1: begin
        if (!din) begin
          state_d = ZERO;
        end else if (&cnt_q) begin
          state_d = ONE;
          tick    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ONE: begin
        if (!din) begin
          state_d = WAIT0;
          cnt_d   = '0;
        end
      end
      default: begin  // WAIT0
        if (din) begin
          state_d = ONE;
        end else if (&cnt_q) begin
          state_d = ZERO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= ZERO;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = (state_q == ONE) || (state_q == WAIT0);
  assign state = state_q;

endmodule

// File: rtl/counter_btn_ctrl.sv
// counter_btn_ctrl: upstream control stage for universal_bin_counter.
//
// Four raw buttons are synchronised and debounced (one debounce_fsm each),
// and their ticks are arbitrated clr > load > up > dn into registered
// one-cycle command pulses. Losing ticks in the same cycle are dropped.
//
// Ports:
//   clk, reset                 clock; synchronous active-low reset
//   btn_up/btn_dn/btn_load/btn_clr  raw asynchronous buttons, active-high
//   sw[N-1:0]                  load value from switches
//   en, up, load, syn_clr      command outputs to the counter
//   d[N-1:0]                   registered load value
//   db_level[3:0]              debounced levels {clr,load,dn,up}
//
// Optional feature macro: AUTO_REPEAT_EN. When defined, holding up or dn
// settled high issues a further tick every 2^REP_W cycles.
module counter_btn_ctrl
  import counter_btn_ctrl_pkg::*;
#(
  parameter int N     = 3,
  parameter int DB_W  = 20,
  parameter int REP_W = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         btn_up,
  input  logic         btn_dn,
  input  logic         btn_load,
  input  logic         btn_clr,
  input  logic [N-1:0] sw,
  output logic         en,
  output logic         up,
  output logic         load,
  output logic         syn_clr,
  output logic [N-1:0] d,
  output logic [3:0]   db_level
);

  logic [NUM_BTN-1:0]      btn_raw;
  logic [NUM_BTN-1:0]      db_tick;
  logic [NUM_BTN-1:0]      cmd_tick;
  logic [NUM_BTN-1:0][1:0] db_state;

  assign btn_raw[CMD_UP]   = btn_up;
  assign btn_raw[CMD_DN]   = btn_dn;
  assign btn_raw[CMD_LOAD] = btn_load;
  assign btn_raw[CMD_CLR]  = btn_clr;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
    debounce_fsm #(.DB_W(DB_W)) u_db (
      .clk     (clk),
      .reset   (reset),
      .din_raw (btn_raw[i]),
      .level   (db_level[i]),
      .tick    (db_tick[i]),
      .state   (db_state[i])
    );
  end

`ifdef AUTO_REPEAT_EN
  // Repeat counters run only while the button sits in ONE; a WAIT0 bounce
  // or release restarts the period from zero.
  logic [REP_W-1:0] rep_up_q, rep_up_d;
  logic [REP_W-1:0] rep_dn_q, rep_dn_d;
  logic             rep_up_tick, rep_dn_tick;

  always_comb begin
    rep_up_d    = '0;
    rep_dn_d    = '0;
    rep_up_tick = 1'b0;
    rep_dn_tick = 1'b0;
    if (db_state[CMD_UP] == ONE) begin
      rep_up_d    = rep_up_q + 1'b1;
      rep_up_tick = &rep_up_q;
    end
    if (db_state[CMD_DN] == ONE) begin
      rep_dn_d    = rep_dn_q + 1'b1;
      rep_dn_tick = &rep_dn_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rep_up_q <= '0;
      rep_dn_q <= '0;
    end else begin
      rep_up_q <= rep_up_d;
      rep_dn_q <= rep_dn_d;
    end
  end

  always_comb begin
    cmd_tick           = db_tick;
    cmd_tick[CMD_UP]   = db_tick[CMD_UP] | rep_up_tick;
    cmd_tick[CMD_DN]   = db_tick[CMD_DN] | rep_dn_tick;
  end
`else
  assign cmd_tick = db_tick;

  // FSM state and REP_W are only consumed by the repeat logic.
  logic unused_rep;
  assign unused_rep = ^{db_state, REP_W[0]};
`endif

  // Output command registers
  logic         en_q, en_d;
  logic         up_q, up_d;
  logic         load_q, load_d;
  logic         clr_q, clr_d;
  logic [N-1:0] d_q, d_d;

  always_comb begin
    en_d   = 1'b0;
    load_d = 1'b0;
    clr_d  = 1'b0;
    up_d   = up_q;
    d_d    = d_q;
    if (cmd_tick[CMD_CLR]) begin
      clr_d = 1'b1;
    end else if (cmd_tick[CMD_LOAD]) begin
      load_d = 1'b1;
      d_d    = sw;
    end else if (cmd_tick[CMD_UP]) begin
      en_d = 1'b1;
      up_d = 1'b1;
    end else if (cmd_tick[CMD_DN]) begin
      en_d = 1'b1;
      up_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      en_q   <= 1'b0;
      up_q   <= 1'b1;
      load_q <= 1'b0;
      clr_q  <= 1'b0;
      d_q    <= '0;
    end else begin
      en_q   <= en_d;
      up_q   <= up_d;
      load_q <= load_d;
      clr_q  <= clr_d;
      d_q    <= d_d;
    end
  end

  assign en      = en_q;
  assign up      = up_q;
  assign load    = load_q;
  assign syn_clr = clr_q;
  assign d       = d_q;

endmodule

// File: tb/tb_counter_btn_ctrl.sv
// Testbench for counter_btn_ctrl with DB_W=3, REP_W=4, N=3.
// Expected latency from raw edge to pulse: 2 + 8 + 1 = 11 cycles.
module tb_counter_btn_ctrl;

  localparam int N     = 3;
  localparam int DB_W  = 3;
  localparam int REP_W = 4;
  localparam int LAT   = 11;
  localparam int REP_P = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic         btn_up = 1'b0, btn_dn = 1'b0, btn_load = 1'b0, btn_clr = 1'b0;
  logic [N-1:0] sw = '0;
  logic         en, up, load, syn_clr;
  logic [N-1:0] d;
  logic [3:0]   db_level;

  counter_btn_ctrl #(.N(N), .DB_W(DB_W), .REP_W(REP_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_up   (btn_up),
    .btn_dn   (btn_dn),
    .btn_load (btn_load),
    .btn_clr  (btn_clr),
    .sw       (sw),
    .en       (en),
    .up       (up),
    .load     (load),
    .syn_clr  (syn_clr),
    .d        (d),
    .db_level (db_level)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] btn;      // {clr,load,dn,up}
    logic [2:0] sw;
    int         hold;
    int         exp_pulses;
    int         exp_lat;
    logic       exp_en;
    logic       exp_up;
    logic       exp_load;
    logic       exp_clr;
    logic [2:0] exp_d;
    logic [3:0] exp_level;
  } vec_t;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_btn(input logic [3:0] b);
    {btn_clr, btn_load, btn_dn, btn_up} = b;
  endtask

  task automatic do_reset(input string tag);
    set_btn(4'b0000);
    reset = 1'b0;
    step();
    step();
    // {en,load,syn_clr,up,d,db_level}
    check({tag, "_reset_state"}, int'({en, load, syn_clr, up, d, db_level}),
          int'({3'b000, 1'b1, 3'b000, 4'b0000}));
    reset = 1'b1;
  endtask

  // Applies buttons right after reset release, holds them 'hold' cycles,
  // then idles 20 more cycles while recording every command pulse.
  task automatic run_vec(input vec_t v, input int idx);
    int pulses, first, last, viol;
    logic [3:0] lvl_or;
    logic f_en, f_up, f_load, f_clr;
    logic [2:0] f_d;
    string tag;
    tag = $sformatf("vec%0d", idx);
    do_reset(tag);
    sw = v.sw;
    set_btn(v.btn);
    pulses = 0; first = -1; last = -1; viol = 0; lvl_or = '0;
    f_en = 0; f_up = 0; f_load = 0; f_clr = 0; f_d = '0;
    for (int c = 1; c <= v.hold + 20; c++) begin
      step();
      lvl_or |= db_level;
      if ($countones({en, load, syn_clr}) > 1) viol++;
      if (en | load | syn_clr) begin
        pulses++;
        if (first < 0) begin
          first = c;
          f_en = en; f_up = up; f_load = load; f_clr = syn_clr; f_d = d;
        end else begin
          check({tag, "_repeat_gap"}, c - last, REP_P);
        end
        last = c;
      end
      if (c == v.hold) set_btn(4'b0000);
    end
    check({tag, "_pulses"}, pulses, v.exp_pulses);
    check({tag, "_onehot"}, viol, 0);
    check({tag, "_level"}, int'(lvl_or), int'(v.exp_level));
    if (v.exp_pulses > 0) begin
      check({tag, "_latency"}, first, v.exp_lat);
      check({tag, "_cmd"}, int'({f_en, f_up, f_load, f_clr}),
            int'({v.exp_en, v.exp_up, v.exp_load, v.exp_clr}));
      check({tag, "_d_at_pulse"}, int'(f_d), int'(v.exp_d));
    end
    // Values hold after the pulse, through idle
    check({tag, "_d_hold"}, int'(d), int'(v.exp_d));
    check({tag, "_up_hold"}, int'(up), int'(v.exp_up));
  endtask

  // ---------------- scoreboard / test ----------------
  vec_t vecs[8];
  int   rep_pulses;

  initial begin
`ifdef AUTO_REPEAT_EN
    rep_pulses = 4;   // first press + 3 repeats while held
`else
    rep_pulses = 1;
`endif
    //         btn      sw      hold pul         lat  en  up  ld  clr d       level
    vecs[0] = '{4'b0001, 3'b000, 20, 1,          LAT, 1, 1, 0, 0, 3'b000, 4'b0001};
    vecs[1] = '{4'b0010, 3'b000, 5,  0,          0,   0, 1, 0, 0, 3'b000, 4'b0000};
    vecs[2] = '{4'b0101, 3'b010, 20, 1,          LAT, 0, 1, 1, 0, 3'b010, 4'b0101};
    vecs[3] = '{4'b1111, 3'b111, 20, 1,          LAT, 0, 1, 0, 1, 3'b000, 4'b1111};
    vecs[4] = '{4'b0010, 3'b000, 20, 1,          LAT, 1, 0, 0, 0, 3'b000, 4'b0010};
    vecs[5] = '{4'b0011, 3'b000, 20, 1,          LAT, 1, 1, 0, 0, 3'b000, 4'b0011};
    vecs[6] = '{4'b0100, 3'b101, 20, 1,          LAT, 0, 1, 1, 0, 3'b101, 4'b0100};
    vecs[7] = '{4'b0001, 3'b000, 71, rep_pulses, LAT, 1, 1, 0, 0, 3'b000, 4'b0001};

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Bouncing dn: 2 high / 2 low x4, then stable high
    begin
      int pulses, first;
      do_reset("bounce");
      pulses = 0;
      for (int k = 0; k < 4; k++) begin
        btn_dn = 1'b1; step(); if (en | load | syn_clr) pulses++;
        step(); if (en | load | syn_clr) pulses++;
        btn_dn = 1'b0; step(); if (en | load | syn_clr) pulses++;
        step(); if (en | load | syn_clr) pulses++;
      end
      check("bounce_no_early_pulse", pulses, 0);
      btn_dn = 1'b1;
      first = -1;
      for (int c = 1; c <= 25; c++) begin
        step();
        if (en | load | syn_clr) begin
          pulses++;
          if (first < 0) begin
            first = c;
            check("bounce_cmd", int'({en, up, load, syn_clr}), int'(4'b1000));
          end
        end
      end
      check("bounce_latency", first, LAT);
      check("bounce_pulses", pulses, 1);
      btn_dn = 1'b0;
    end

    // Reset during clr debounce aborts it; held button re-presses after release
    begin
      int pulses, first;
      do_reset("rst_mid");
      btn_clr = 1'b1;
      pulses = 0;
      for (int c = 1; c <= 5; c++) begin
        step();
        if (en | load | syn_clr) pulses++;
      end
      reset = 1'b0;
      step();
      check("rst_mid_no_pulse_before", pulses, 0);
      check("rst_mid_level_cleared", int'(db_level), 0);
      reset = 1'b1;
      first = -1;
      for (int c = 1; c <= 20; c++) begin
        step();
        if (en | load | syn_clr) begin
          pulses++;
          if (first < 0) begin
            first = c;
            check("rst_mid_cmd", int'({en, load, syn_clr}), int'(3'b001));
          end
        end
      end
      check("rst_mid_latency", first, LAT);
      check("rst_mid_pulses", pulses, 1);
      btn_clr = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
